// File: rtl/lpc.sv
// rtl/lpc.sv - passive LPC bus sniffer decoding I/O and memory read/write cycles
module lpc (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  lpc_ad,
    input  logic        lpc_frame,
    output logic [3:0]  out_cyctype_dir,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic [2:0]  out_data_size,
    output logic        out_clock_enable
);

    typedef enum logic [3:0] {
        IDLE,
        CTDIR,
        ADDR,
        TAR1,
        TAR2,
        SYNC,
        DATA0,
        DATA1,
        TAR3,
        TAR4
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  ct;
    logic [3:0]  cnt;
    logic [31:0] addr;
    logic [7:0]  data;
    logic        emit;
    logic        start;

    assign start = !lpc_frame && (lpc_ad == 4'b0000);

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        case (state)
            IDLE:  next_state = IDLE;
            CTDIR: next_state = (lpc_ad[3] == 1'b0) ? ADDR : IDLE;
            ADDR: begin
                if (cnt == 4'd1) begin
                    next_state = ct[0] ? DATA0 : TAR1;
                end
            end
            TAR1:  next_state = TAR2;
            TAR2:  next_state = SYNC;
            SYNC: begin
                if (lpc_ad == 4'b0000) begin
                    // Writes complete on ready SYNC; reads still have data to come.
                    if (ct[0]) begin
                        emit       = 1'b1;
                        next_state = TAR3;
                    end else begin
                        next_state = DATA0;
                    end
                end else if (lpc_ad == 4'b0101 || lpc_ad == 4'b0110) begin
                    next_state = SYNC;
                end else begin
                    next_state = IDLE;
                end
            end
            DATA0: next_state = DATA1;
            DATA1: begin
                if (ct[0]) begin
                    next_state = TAR1;
                end else begin
                    emit       = 1'b1;
                    next_state = TAR3;
                end
            end
            TAR3:  next_state = TAR4;
            TAR4:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // A low LFRAME# overrides everything, including a would-be completion.
        if (!lpc_frame) begin
            next_state = start ? CTDIR : IDLE;
            emit       = 1'b0;
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state            <= IDLE;
            ct               <= 3'd0;
            cnt              <= 4'd0;
            addr             <= 32'd0;
            data             <= 8'd0;
            out_cyctype_dir  <= 4'd0;
            out_addr         <= 32'd0;
            out_data         <= 32'd0;
            out_data_size    <= 3'd0;
            out_clock_enable <= 1'b0;
        end else begin
            state            <= next_state;
            out_clock_enable <= emit;
            if (!lpc_frame) begin
                if (start) begin
                    addr <= 32'd0;
                    data <= 8'd0;
                end
            end else begin
                case (state)
                    CTDIR: begin
                        ct  <= lpc_ad[3:1];
                        cnt <= lpc_ad[2] ? 4'd8 : 4'd4;
                    end
                    ADDR: begin
                        addr <= {addr[27:0], lpc_ad};
                        cnt  <= cnt - 4'd1;
                    end
                    DATA0: data[3:0] <= lpc_ad;
                    DATA1: data[7:4] <= lpc_ad;
                    default: ;
                endcase
            end
            if (emit) begin
                out_cyctype_dir <= {ct, 1'b0};
                out_addr        <= addr;
                // On a read the high data nibble arrives on the completing sample itself.
                out_data        <= {24'd0, (state == DATA1) ? {lpc_ad, data[3:0]} : data};
                out_data_size   <= 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_lpc.sv
// tb/tb_lpc.sv - randomized transaction-level check of the lpc sniffer
module tb_lpc;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset;
    logic [3:0]  lpc_ad;
    logic        lpc_frame;
    logic [3:0]  out_cyctype_dir;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [2:0]  out_data_size;
    logic        out_clock_enable;

    lpc dut (
        .lpc_clock        (lpc_clock),
        .lpc_reset        (lpc_reset),
        .lpc_ad           (lpc_ad),
        .lpc_frame        (lpc_frame),
        .out_cyctype_dir  (out_cyctype_dir),
        .out_addr         (out_addr),
        .out_data         (out_data),
        .out_data_size    (out_data_size),
        .out_clock_enable (out_clock_enable)
    );

    always #5 lpc_clock = ~lpc_clock;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0]  exp_ct[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    logic [3:0]  last_ct;
    logic [31:0] last_addr;
    logic [31:0] last_data;
    logic [2:0]  last_size;

    localparam int OK = 0, ERR = 1, ABORT = 2, BADTYPE = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (out_clock_enable === 1'b1) begin
            if (exp_ct.size() == 0) begin
                check("spurious_strobe", 32'd1, 32'd0);
            end else begin
                last_ct   = exp_ct.pop_front();
                last_addr = exp_addr.pop_front();
                last_data = exp_data.pop_front();
                last_size = 3'd1;
                check("rec_ct", 32'(out_cyctype_dir), 32'(last_ct));
                check("rec_addr", out_addr, last_addr);
                check("rec_data", out_data, last_data);
                check("rec_size", 32'(out_data_size), 32'(last_size));
            end
        end else begin
            check("hold_ct", 32'(out_cyctype_dir), 32'(last_ct));
            check("hold_addr", out_addr, last_addr);
            check("hold_data", out_data, last_data);
            check("hold_size", 32'(out_data_size), 32'(last_size));
        end
    endtask

    task automatic step(input logic frame, input logic [3:0] ad);
        lpc_frame = frame;
        lpc_ad    = ad;
        @(posedge lpc_clock);
        #1;
        monitor();
    endtask

    function automatic logic [3:0] bad_sync();
        logic [3:0] v;
        v = 4'(($urandom_range(15)));
        while (v == 4'h0 || v == 4'h5 || v == 4'h6) v = 4'(($urandom_range(15)));
        return v;
    endfunction

    task automatic do_cycle(input bit is_mem, input bit is_write, input logic [31:0] a,
                            input logic [7:0] d, input int nwait, input int outcome,
                            input int abort_at, input bit overlap);
        int nn;
        logic [31:0] ea;
        nn = is_mem ? 8 : 4;
        ea = is_mem ? a : {16'd0, a[15:0]};
        if (outcome == OK) begin
            exp_ct.push_back({1'b0, is_mem, is_write, 1'b0});
            exp_addr.push_back(ea);
            exp_data.push_back({24'd0, d});
        end
        step(1'b0, 4'h0);
        if (outcome == BADTYPE) begin
            step(1'b1, {1'b1, 3'(($urandom_range(7)))});
            return;
        end
        step(1'b1, {1'b0, is_mem, is_write, 1'b0});
        for (int i = 0; i < nn; i++) begin
            if (outcome == ABORT && i == abort_at) return;
            step(1'b1, ea[4*(nn-1-i) +: 4]);
        end
        if (is_write) begin
            step(1'b1, d[3:0]);
            step(1'b1, d[7:4]);
        end
        step(1'b1, 4'hf);
        step(1'b1, 4'(($urandom_range(15))));
        for (int w = 0; w < nwait; w++) step(1'b1, ($urandom_range(1) != 0) ? 4'h5 : 4'h6);
        if (outcome == ERR) begin
            step(1'b1, (nwait == 0) ? 4'ha : bad_sync());
            return;
        end
        step(1'b1, 4'h0);
        if (!is_write) begin
            step(1'b1, d[3:0]);
            step(1'b1, d[7:4]);
        end
        step(1'b1, 4'hf);
        if (!overlap) step(1'b1, 4'(($urandom_range(15))));
    endtask

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 4'(($urandom_range(15))));
    endtask

    initial begin
        last_ct   = 4'd0;
        last_addr = 32'd0;
        last_data = 32'd0;
        last_size = 3'd0;
        lpc_reset = 1'b0;
        lpc_frame = 1'b1;
        lpc_ad    = 4'h0;
        #2;
        check("reset_strobe", 32'(out_clock_enable), 32'd0);
        check("reset_ct", 32'(out_cyctype_dir), 32'd0);
        check("reset_addr", out_addr, 32'd0);
        check("reset_data", out_data, 32'd0);
        check("reset_size", 32'(out_data_size), 32'd0);
        #20;
        lpc_reset = 1'b1;
        idles(2);

        // Directed cases
        do_cycle(1'b0, 1'b0, 32'h7fe5, 8'h6c, 0, OK, 0, 1'b0);
        idles(1);
        do_cycle(1'b0, 1'b0, 32'h7fe4, 8'h6b, 0, OK, 0, 1'b1);
        do_cycle(1'b0, 1'b0, 32'h7fe5, 8'h6c, 0, OK, 0, 1'b0);
        do_cycle(1'b0, 1'b1, 32'h0080, 8'ha5, 0, OK, 0, 1'b0);
        do_cycle(1'b1, 1'b0, 32'hfffffff0, 8'h3c, 3, OK, 0, 1'b0);
        do_cycle(1'b0, 1'b0, 32'h1234, 8'h55, 0, ERR, 0, 1'b0);
        do_cycle(1'b0, 1'b0, 32'h4321, 8'haa, 0, OK, 0, 1'b0);
        do_cycle(1'b1, 1'b1, 32'h89abcdef, 8'h11, 0, ABORT, 3, 1'b0);
        do_cycle(1'b1, 1'b1, 32'h13572468, 8'h9e, 1, OK, 0, 1'b0);
        do_cycle(1'b0, 1'b1, 32'h00ff, 8'h01, 0, BADTYPE, 0, 1'b0);
        idles(2);

        // Asynchronous reset in the middle of an address phase
        step(1'b0, 4'h0);
        step(1'b1, 4'h4);
        step(1'b1, 4'hd);
        step(1'b1, 4'he);
        #2;
        lpc_reset = 1'b0;
        last_ct   = 4'd0;
        last_addr = 32'd0;
        last_data = 32'd0;
        last_size = 3'd0;
        #1;
        check("async_strobe", 32'(out_clock_enable), 32'd0);
        check("async_addr", out_addr, 32'd0);
        check("async_data", out_data, 32'd0);
        check("async_ct", 32'(out_cyctype_dir), 32'd0);
        idles(2);
        lpc_reset = 1'b1;
        idles(1);
        do_cycle(1'b0, 1'b0, 32'hbeef, 8'hc3, 2, OK, 0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            bit is_mem, is_write, ovl;
            int r, oc;
            is_mem   = ($urandom_range(1) != 0);
            is_write = ($urandom_range(1) != 0);
            ovl      = ($urandom_range(1) != 0);
            r        = int'($urandom_range(9));
            oc       = (r == 6) ? ERR : (r == 7) ? ABORT : (r == 8) ? BADTYPE : OK;
            do_cycle(is_mem, is_write, $urandom, 8'(($urandom_range(255))),
                     int'($urandom_range(3)), oc,
                     int'($urandom_range(is_mem ? 7 : 3)), ovl);
            if (oc != ABORT && !(oc == OK && ovl)) idles(int'($urandom_range(2)));
        end
        do_cycle(1'b0, 1'b1, 32'h5a5a, 8'h77, 0, OK, 0, 1'b0);
        idles(3);

        check("records_left", 32'(exp_ct.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
